// File: rtl/semaphore_pkg.sv
// Shared state codes and lamp patterns for the intersection phase sequencer.
package semaphore_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALL_RED1  = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALL_RED2  = 3'd5,
    ST_PED_WALK  = 3'd6,
    ST_SERVICE   = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/semaphore_ctrl_if.sv
// Time-base/request inputs and lamp/debug outputs of the phase sequencer.
interface semaphore_ctrl_if;
  logic       tick;
  logic       service;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output tick, service, ped_req,
    input  ns_light, ew_light, ped_walk, ped_ack, phase
  );

  modport slave (
    input  tick, service, ped_req,
    output ns_light, ew_light, ped_walk, ped_ack, phase
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter stepped by tick; expire flags a tick seen at count zero.
// Load wins over decrement; expire is combinational from the registered count.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = tick && (cnt == '0);

endmodule

// File: rtl/semaphore_ctrl.sv
// Intersection phase sequencer: green -> yellow -> all-red per road, optional ped walk, service flash.
// All outputs registered; a new phase shows one cycle after its terminal tick or the service edge.
module semaphore_ctrl
  import semaphore_pkg::*;
#(
  parameter int T_GREEN_NS = 6,
  parameter int T_GREEN_EW = 6,
  parameter int T_YELLOW   = 2,
  parameter int T_ALLRED   = 1,
  parameter int T_PED      = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  semaphore_ctrl_if.slave  bus
);

  state_t           state, nxt_state;
  logic             ped_pending, nxt_pending;
  logic             flash, nxt_flash;
  logic             expire, load;
  logic [CNT_W-1:0] load_val;

  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      ST_NS_GREEN:               return CNT_W'(T_GREEN_NS - 1);
      ST_EW_GREEN:               return CNT_W'(T_GREEN_EW - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: return CNT_W'(T_YELLOW - 1);
      ST_PED_WALK:               return CNT_W'(T_PED - 1);
      ST_SERVICE:                return '0;
      default:                   return CNT_W'(T_ALLRED - 1);
    endcase
  endfunction

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(T_ALLRED - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (bus.tick),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // Service overrides the timer; leaving service always goes through all-red.
  always_comb begin
    nxt_state = state;
    if (state != ST_SERVICE && bus.service) begin
      nxt_state = ST_SERVICE;
    end else if (state == ST_SERVICE) begin
      nxt_state = bus.service ? ST_SERVICE : ST_ALL_RED2;
    end else if (expire) begin
      case (state)
        ST_NS_GREEN:  nxt_state = ST_NS_YELLOW;
        ST_NS_YELLOW: nxt_state = ST_ALL_RED1;
        ST_ALL_RED1:  nxt_state = ST_EW_GREEN;
        ST_EW_GREEN:  nxt_state = ST_EW_YELLOW;
        ST_EW_YELLOW: nxt_state = ST_ALL_RED2;
        ST_ALL_RED2:  nxt_state = ped_pending ? ST_PED_WALK : ST_NS_GREEN;
        default:      nxt_state = ST_NS_GREEN;
      endcase
    end
  end

  always_comb begin
    load     = (nxt_state != state);
    load_val = dur_m1(nxt_state);

    nxt_pending = ped_pending;
    if (load && (nxt_state == ST_SERVICE || nxt_state == ST_PED_WALK)) begin
      nxt_pending = 1'b0;
    end else if (bus.ped_req && state != ST_PED_WALK && state != ST_SERVICE) begin
      nxt_pending = 1'b1;
    end

    nxt_flash = flash;
    if (state != ST_SERVICE && nxt_state == ST_SERVICE) begin
      nxt_flash = 1'b1;
    end else if (state == ST_SERVICE && nxt_state == ST_SERVICE && bus.tick) begin
      nxt_flash = ~flash;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_ALL_RED2;
      ped_pending  <= 1'b0;
      flash        <= 1'b1;
      bus.ns_light <= LAMP_RED;
      bus.ew_light <= LAMP_RED;
      bus.ped_walk <= 1'b0;
      bus.ped_ack  <= 1'b0;
    end else begin
      state        <= nxt_state;
      ped_pending  <= nxt_pending;
      flash        <= nxt_flash;
      bus.ped_walk <= (nxt_state == ST_PED_WALK);
      bus.ped_ack  <= (nxt_state == ST_PED_WALK) && (state != ST_PED_WALK);
      case (nxt_state)
        ST_NS_GREEN:  begin bus.ns_light <= LAMP_GRN; bus.ew_light <= LAMP_RED; end
        ST_NS_YELLOW: begin bus.ns_light <= LAMP_YEL; bus.ew_light <= LAMP_RED; end
        ST_EW_GREEN:  begin bus.ns_light <= LAMP_RED; bus.ew_light <= LAMP_GRN; end
        ST_EW_YELLOW: begin bus.ns_light <= LAMP_RED; bus.ew_light <= LAMP_YEL; end
        ST_SERVICE: begin
          bus.ns_light <= nxt_flash ? LAMP_YEL : LAMP_OFF;
          bus.ew_light <= nxt_flash ? LAMP_YEL : LAMP_OFF;
        end
        default:      begin bus.ns_light <= LAMP_RED; bus.ew_light <= LAMP_RED; end
      endcase
    end
  end

  assign bus.phase = state;

  a_ns_grn_safe: assert property (@(posedge clk) !(bus.ns_light[0] && !bus.ew_light[2]));
  a_ew_grn_safe: assert property (@(posedge clk) !(bus.ew_light[0] && !bus.ns_light[2]));
  a_walk_safe:   assert property (@(posedge clk)
    !bus.ped_walk || (bus.ns_light == LAMP_RED && bus.ew_light == LAMP_RED));

endmodule
